// File: rtl/iob_uart_csr_manager.sv
`default_nettype none
// ============================================================================
// Module   : iob_uart_csr_manager
// Brief    : IOb bus manager for an iob_uart CSR port. Soft-resets and
//            configures the UART, then polls status and moves bytes between
//            valid/ready streams and the TXDATA/RXDATA registers.
// Revision : 1.0 - initial release
// ============================================================================
module iob_uart_csr_manager #(
  parameter int FREQ    = 100000000,
  parameter int BAUD    = 3000000,
  parameter int DIV_VAL = FREQ / BAUD
) (
  input  logic        clk_i,
  input  logic        cke_i,
  input  logic        arst_i,
  input  logic        tx_valid_i,
  input  logic [7:0]  tx_data_i,
  output logic        tx_ready_o,
  output logic        rx_valid_o,
  output logic [7:0]  rx_data_o,
  input  logic        rx_ready_i,
  output logic        init_done_o,
  output logic        iob_valid_o,
  output logic [2:0]  iob_addr_o,
  output logic [31:0] iob_wdata_o,
  output logic [3:0]  iob_wstrb_o,
  input  logic        iob_rvalid_i,
  input  logic [31:0] iob_rdata_i,
  input  logic        iob_ready_i
);

  localparam logic [2:0]  C_ADDR_CTRL = 3'd0;
  localparam logic [2:0]  C_ADDR_DATA = 3'd4;
  localparam logic [15:0] C_DIV       = 16'(DIV_VAL);

  typedef enum logic [3:0] {
    S_RST_SET = 4'd0,
    S_RST_CLR = 4'd1,
    S_SET_DIV = 4'd2,
    S_SET_EN  = 4'd3,
    S_IDLE    = 4'd4,
    S_POLL    = 4'd5,
    S_POLL_RV = 4'd6,
    S_TX_WR   = 4'd7,
    S_RX_RD   = 4'd8,
    S_RX_RV   = 4'd9
  } state_t;

  state_t      state_q, state_d;
  logic        valid_q, valid_d;
  logic [2:0]  addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [7:0]  tx_byte_q, tx_byte_d;
  logic        rx_valid_q, rx_valid_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        init_done_q, init_done_d;

  // Request descriptor for the current state, consumed by the common issue logic
  logic        w_req_en;
  logic [2:0]  w_req_addr;
  logic [3:0]  w_req_wstrb;
  logic [31:0] w_req_wdata;
  state_t      w_req_next;

  // Only the low byte of read data carries status or RX data
  logic        w_unused_rdata;
  assign w_unused_rdata = ^iob_rdata_i[31:8];

  // Next-state, request issue and stream-side bookkeeping
  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    tx_byte_d   = tx_byte_q;
    rx_valid_d  = rx_valid_q;
    rx_data_d   = rx_data_q;
    init_done_d = init_done_q;
    w_req_en    = 1'b0;
    w_req_addr  = C_ADDR_CTRL;
    w_req_wstrb = 4'b0000;
    w_req_wdata = 32'h0;
    w_req_next  = state_q;

    // Consumer handshake frees the RX holding register
    if (rx_valid_q && rx_ready_i) begin
      rx_valid_d = 1'b0;
    end

    case (state_q)
      S_RST_SET: begin
        w_req_en    = 1'b1;
        w_req_wstrb = 4'b0001;
        w_req_wdata = 32'h1;
        w_req_next  = S_RST_CLR;
      end
      S_RST_CLR: begin
        w_req_en    = 1'b1;
        w_req_wstrb = 4'b0001;
        w_req_next  = S_SET_DIV;
      end
      S_SET_DIV: begin
        w_req_en    = 1'b1;
        w_req_wstrb = 4'b1100;
        w_req_wdata = {C_DIV, 16'h0};
        w_req_next  = S_SET_EN;
      end
      S_SET_EN: begin
        w_req_en    = 1'b1;
        w_req_addr  = C_ADDR_DATA;
        w_req_wstrb = 4'b0110;
        w_req_wdata = 32'h0001_0100;
        w_req_next  = S_IDLE;
      end
      S_IDLE: begin
        // Poll only when there is work: a byte to send or room for one
        if (tx_valid_i || !rx_valid_q) begin
          state_d = S_POLL;
        end
      end
      S_POLL: begin
        w_req_en   = 1'b1;
        w_req_next = S_POLL_RV;
      end
      S_POLL_RV: begin
        if (iob_rvalid_i) begin
          if (iob_rdata_i[0] && tx_valid_i) begin
            // Latch the byte so the write completes even if upstream drops valid
            tx_byte_d = tx_data_i;
            state_d   = S_TX_WR;
          end else if (iob_rdata_i[1] && !rx_valid_q) begin
            state_d = S_RX_RD;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_TX_WR: begin
        w_req_en    = 1'b1;
        w_req_addr  = C_ADDR_DATA;
        w_req_wstrb = 4'b0001;
        w_req_wdata = {24'h0, tx_byte_q};
        w_req_next  = S_IDLE;
      end
      S_RX_RD: begin
        w_req_en   = 1'b1;
        w_req_addr = C_ADDR_DATA;
        w_req_next = S_RX_RV;
      end
      S_RX_RV: begin
        if (iob_rvalid_i) begin
          rx_data_d  = iob_rdata_i[7:0];
          rx_valid_d = 1'b1;
          state_d    = S_IDLE;
        end
      end
      default: begin
        state_d = S_RST_SET;
      end
    endcase

    // Common issue: raise valid with the request, hold it until accepted,
    // then drop valid and advance.
    if (w_req_en) begin
      if (!valid_q) begin
        valid_d = 1'b1;
        addr_d  = w_req_addr;
        wstrb_d = w_req_wstrb;
        wdata_d = w_req_wdata;
      end else if (iob_ready_i) begin
        valid_d = 1'b0;
        state_d = w_req_next;
        if (state_q == S_SET_EN) begin
          init_done_d = 1'b1;
        end
      end
    end
  end

  // State and output registers; cke_i freezes everything, reset wins
  always_ff @(posedge clk_i) begin
    if (arst_i) begin
      state_q     <= S_RST_SET;
      valid_q     <= 1'b0;
      addr_q      <= 3'd0;
      wdata_q     <= 32'h0;
      wstrb_q     <= 4'b0000;
      tx_byte_q   <= 8'h0;
      rx_valid_q  <= 1'b0;
      rx_data_q   <= 8'h0;
      init_done_q <= 1'b0;
    end else if (cke_i) begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      tx_byte_q   <= tx_byte_d;
      rx_valid_q  <= rx_valid_d;
      rx_data_q   <= rx_data_d;
      init_done_q <= init_done_d;
    end
  end

  // Upstream sees acceptance in the cycle the TXDATA write handshakes
  assign tx_ready_o  = (state_q == S_TX_WR) && valid_q && iob_ready_i && cke_i;
  assign rx_valid_o  = rx_valid_q;
  assign rx_data_o   = rx_data_q;
  assign init_done_o = init_done_q;
  assign iob_valid_o = valid_q;
  assign iob_addr_o  = addr_q;
  assign iob_wdata_o = wdata_q;
  assign iob_wstrb_o = wstrb_q;

endmodule
`default_nettype wire

// File: tb/tb_iob_uart_csr_manager.sv
`default_nettype none
// ============================================================================
// Module   : tb_iob_uart_csr_manager
// Brief    : Directed self-checking bench with an IOb responder model that
//            logs accepted requests and returns scripted read data.
// Revision : 1.0 - initial release
// ============================================================================
module tb_iob_uart_csr_manager;

  logic        clk = 1'b0;
  logic        cke = 1'b1;
  logic        arst = 1'b1;
  logic        tx_valid = 1'b0;
  logic [7:0]  tx_data = 8'h0;
  logic        tx_ready;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready = 1'b0;
  logic        init_done;
  logic        iob_valid;
  logic [2:0]  iob_addr;
  logic [31:0] iob_wdata;
  logic [3:0]  iob_wstrb;
  logic        iob_rvalid = 1'b0;
  logic [31:0] iob_rdata = 32'h0;
  logic        resp_ready = 1'b1;

  int errors = 0;
  int checks = 0;

  // Responder state
  int          resp_delay = 1;
  logic        rd_pend = 1'b0;
  int          rd_cnt = 0;
  logic [31:0] rd_val = 32'h0;
  logic [31:0] stat_q[$];
  logic [31:0] rxd_q[$];
  logic [2:0]  lg_addr[$];
  logic [3:0]  lg_strb[$];
  logic [31:0] lg_wdata[$];
  int          tx_rdy_cnt = 0;

  iob_uart_csr_manager dut (
    .clk_i       (clk),
    .cke_i       (cke),
    .arst_i      (arst),
    .tx_valid_i  (tx_valid),
    .tx_data_i   (tx_data),
    .tx_ready_o  (tx_ready),
    .rx_valid_o  (rx_valid),
    .rx_data_o   (rx_data),
    .rx_ready_i  (rx_ready),
    .init_done_o (init_done),
    .iob_valid_o (iob_valid),
    .iob_addr_o  (iob_addr),
    .iob_wdata_o (iob_wdata),
    .iob_wstrb_o (iob_wstrb),
    .iob_rvalid_i(iob_rvalid),
    .iob_rdata_i (iob_rdata),
    .iob_ready_i (resp_ready)
  );

  always #5 clk = ~clk;

  // IOb responder: log accepted requests, answer reads after resp_delay cycles
  always @(posedge clk) begin
    iob_rvalid <= 1'b0;
    if (rd_pend) begin
      if (rd_cnt <= 1) begin
        iob_rvalid <= 1'b1;
        iob_rdata  <= rd_val;
        rd_pend    <= 1'b0;
      end else begin
        rd_cnt <= rd_cnt - 1;
      end
    end
    if (iob_valid && resp_ready && cke && !arst) begin
      lg_addr.push_back(iob_addr);
      lg_strb.push_back(iob_wstrb);
      lg_wdata.push_back(iob_wdata);
      if (iob_wstrb == 4'b0000) begin
        rd_pend <= 1'b1;
        rd_cnt  <= resp_delay;
        if (iob_addr == 3'd0) begin
          if (stat_q.size() > 0) rd_val <= stat_q.pop_front();
          else                   rd_val <= 32'h0;
        end else begin
          if (rxd_q.size() > 0)  rd_val <= rxd_q.pop_front();
          else                   rd_val <= 32'h0;
        end
      end
    end
    if (tx_ready) tx_rdy_cnt <= tx_rdy_cnt + 1;
  end

  function automatic int find_req(input logic [2:0] a, input logic [3:0] s, input int from);
    for (int i = from; i < lg_addr.size(); i++) begin
      if (lg_addr[i] == a && lg_strb[i] == s) return i;
    end
    return -1;
  endfunction

  function automatic logic [38:0] entry(input int i);
    return {lg_addr[i], lg_strb[i], lg_wdata[i]};
  endfunction

  task automatic wait_log(input int n, input int budget, input string name);
    int k;
    k = 0;
    while (lg_addr.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (lg_addr.size() < n) begin
      errors++;
      $display("FAIL %s: timeout, log size %0d required %0d", name, lg_addr.size(), n);
    end
  endtask

  task automatic check_init_seq(input int base, input string name);
    logic [38:0] exp_e[4];
    exp_e[0] = {3'd0, 4'b0001, 32'h0000_0001};
    exp_e[1] = {3'd0, 4'b0001, 32'h0000_0000};
    exp_e[2] = {3'd0, 4'b1100, 32'h0021_0000};
    exp_e[3] = {3'd4, 4'b0110, 32'h0001_0100};
    wait_log(base + 4, 200, name);
    for (int k = 0; k < 4; k++) begin
      if (base + k < lg_addr.size()) begin
        checks++;
        if (entry(base + k) !== exp_e[k]) begin
          errors++;
          $display("FAIL %s[%0d]: got %h required %h", name, k, entry(base + k), exp_e[k]);
        end
      end
    end
    checks++;
    if (init_done !== 1'b1) begin
      errors++;
      $display("FAIL %s init_done: got %b required 1", name, init_done);
    end
  endtask

  task automatic test_reset();
    arst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({iob_valid, iob_addr, iob_wdata, iob_wstrb, tx_ready, rx_valid, rx_data, init_done} !== 55'h0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b addr=%h wdata=%h wstrb=%b txr=%b rxv=%b rxd=%h done=%b required all 0",
               iob_valid, iob_addr, iob_wdata, iob_wstrb, tx_ready, rx_valid, rx_data, init_done);
    end
  endtask

  task automatic test_init();
    int base;
    base = lg_addr.size();
    arst = 1'b0;
    @(negedge clk);
    checks++;
    if (init_done !== 1'b0) begin
      errors++;
      $display("FAIL init_done_early: got %b required 0", init_done);
    end
    check_init_seq(base, "init_seq");
  endtask

  task automatic test_tx();
    int base, trb, k, nw, iw;
    base = lg_addr.size();
    trb = tx_rdy_cnt;
    stat_q.push_back(32'h0);
    stat_q.push_back(32'h0);
    stat_q.push_back(32'h1);
    tx_data = 8'hA5;
    tx_valid = 1'b1;
    k = 0;
    while (!tx_ready && k < 300) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL tx_ready_seen: got %b required 1", tx_ready);
    end
    tx_valid = 1'b0;
    repeat (10) @(negedge clk);
    nw = 0;
    iw = -1;
    for (int i = base; i < lg_addr.size(); i++) begin
      if (lg_strb[i] != 4'b0000) begin
        nw++;
        iw = i;
      end
    end
    checks++;
    if (nw != 1) begin
      errors++;
      $display("FAIL tx_write_count: got %0d required 1", nw);
    end
    if (iw >= 0) begin
      checks++;
      if (entry(iw) !== {3'd4, 4'b0001, 32'h0000_00A5}) begin
        errors++;
        $display("FAIL tx_write: got %h required %h", entry(iw), {3'd4, 4'b0001, 32'h0000_00A5});
      end
    end
    checks++;
    if (tx_rdy_cnt - trb != 1) begin
      errors++;
      $display("FAIL tx_ready_pulses: got %0d required 1", tx_rdy_cnt - trb);
    end
    checks++;
    if (stat_q.size() != 0) begin
      errors++;
      $display("FAIL tx_polls_consumed: got %0d left required 0", stat_q.size());
    end
  endtask

  task automatic test_rx_backpressure();
    int k, base;
    stat_q.push_back(32'h2);
    rxd_q.push_back(32'h0000_003C);
    k = 0;
    while (!rx_valid && k < 300) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (rx_valid !== 1'b1 || rx_data !== 8'h3C) begin
      errors++;
      $display("FAIL rx_capture: got valid=%b data=%h required 1/3c", rx_valid, rx_data);
    end
    base = lg_addr.size();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if (rx_valid !== 1'b1 || rx_data !== 8'h3C) begin
        errors++;
        $display("FAIL rx_hold[%0d]: got valid=%b data=%h required 1/3c", c, rx_valid, rx_data);
      end
    end
    checks++;
    if (lg_addr.size() != base) begin
      errors++;
      $display("FAIL rx_no_traffic: got %0d requests required 0", lg_addr.size() - base);
    end
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    checks++;
    if (rx_valid !== 1'b0) begin
      errors++;
      $display("FAIL rx_release: got %b required 0", rx_valid);
    end
  endtask

  task automatic test_priority();
    int base, k, iw, ir;
    base = lg_addr.size();
    stat_q.push_back(32'h3);
    stat_q.push_back(32'h2);
    rxd_q.push_back(32'h0000_0077);
    tx_data = 8'h55;
    tx_valid = 1'b1;
    k = 0;
    while (!tx_ready && k < 300) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (tx_ready !== 1'b1 || iob_wdata !== 32'h0000_0055) begin
      errors++;
      $display("FAIL prio_tx: got ready=%b wdata=%h required 1/00000055", tx_ready, iob_wdata);
    end
    tx_valid = 1'b0;
    k = 0;
    while (!rx_valid && k < 300) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (rx_valid !== 1'b1 || rx_data !== 8'h77) begin
      errors++;
      $display("FAIL prio_rx: got valid=%b data=%h required 1/77", rx_valid, rx_data);
    end
    iw = find_req(3'd4, 4'b0001, base);
    ir = find_req(3'd4, 4'b0000, base);
    checks++;
    if (iw < 0 || ir <= iw) begin
      errors++;
      $display("FAIL prio_order: got write idx %0d read idx %0d required write before read", iw, ir);
    end
  endtask

  task automatic test_reset_mid();
    int base, k, ir, bad;
    // Reset with a byte held: it is discarded and init restarts
    base = lg_addr.size();
    checks++;
    if (rx_valid !== 1'b1) begin
      errors++;
      $display("FAIL rst_precond: got rx_valid=%b required 1", rx_valid);
    end
    arst = 1'b1;
    @(negedge clk);
    arst = 1'b0;
    checks++;
    if (rx_valid !== 1'b0 || iob_valid !== 1'b0 || init_done !== 1'b0) begin
      errors++;
      $display("FAIL rst_held: got rxv=%b valid=%b done=%b required 0/0/0", rx_valid, iob_valid, init_done);
    end
    check_init_seq(base, "rst_held_init");
    // Reset while the RX read waits for a slow rvalid
    resp_delay = 6;
    stat_q.push_back(32'h2);
    rxd_q.push_back(32'h0000_00EE);
    k = 0;
    ir = -1;
    while (ir < 0 && k < 300) begin
      @(negedge clk);
      ir = find_req(3'd4, 4'b0000, base + 4);
      k++;
    end
    checks++;
    if (ir < 0) begin
      errors++;
      $display("FAIL rst_mid_rxread: got none required addr4 read");
    end
    base = lg_addr.size();
    arst = 1'b1;
    @(negedge clk);
    arst = 1'b0;
    checks++;
    if (iob_valid !== 1'b0 || rx_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid: got valid=%b rxv=%b required 0/0", iob_valid, rx_valid);
    end
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (rx_valid !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL rst_late_rvalid: got rx_valid high %0d cycles required 0", bad);
    end
    resp_delay = 1;
    check_init_seq(base, "rst_mid_init");
  endtask

  task automatic test_stall_freeze();
    int base, k;
    logic [38:0] exp_div;
    exp_div = {3'd0, 4'b1100, 32'h0021_0000};
    arst = 1'b1;
    @(negedge clk);
    arst = 1'b0;
    base = lg_addr.size();
    wait_log(base + 2, 100, "stall_pre");
    resp_ready = 1'b0;
    k = 0;
    while (!iob_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    for (int c = 0; c < 7; c++) begin
      checks++;
      if ({iob_valid, iob_addr, iob_wstrb, iob_wdata} !== {1'b1, exp_div}) begin
        errors++;
        $display("FAIL stall[%0d]: got valid=%b req=%h required 1/%h", c, iob_valid,
                 {iob_addr, iob_wstrb, iob_wdata}, exp_div);
      end
      @(negedge clk);
    end
    cke = 1'b0;
    resp_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if ({iob_valid, iob_addr, iob_wstrb, iob_wdata} !== {1'b1, exp_div} || lg_addr.size() != base + 2) begin
        errors++;
        $display("FAIL freeze[%0d]: got valid=%b req=%h log=%0d required 1/%h/%0d", c, iob_valid,
                 {iob_addr, iob_wstrb, iob_wdata}, lg_addr.size() - base, exp_div, 2);
      end
    end
    cke = 1'b1;
    check_init_seq(base, "stall_init");
  endtask

  initial begin
    test_reset();
    test_init();
    test_tx();
    test_rx_backpressure();
    test_priority();
    test_reset_mid();
    test_stall_freeze();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute time limit so the bench always ends
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
